// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit RISC core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction and data memory, gates datapath control to the active phase,
// resolves BEQ/BNE/JMP PC updates and counts retired instructions.
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_JMP
  } class_e;

  state_e            state_q, state_d;
  class_e            class_q, class_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              err_q, err_d;
  logic              retire;
  logic              timeout;

  // Classify the opcode; only consumed while in DECODE.
  always_comb begin
    unique case (opcode)
      4'b0000: class_d = C_LW;
      4'b0001: class_d = C_SW;
      4'b1010: class_d = C_BEQ;
      4'b1011: class_d = C_BNE;
      4'b1100: class_d = C_JMP;
      default: class_d = C_RTYPE;
    endcase
  end

  // The current wait cycle is the last one allowed before giving up.
  assign timeout = (wait_q == WAIT_LAST);

  // Phase-gated control outputs, retirement and next-state selection.
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d    = state_q;
    wait_d     = wait_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (class_q)
          C_LW, C_SW: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            state_d = S_MEM;
            wait_d  = '0;
          end
          C_BEQ: begin
            alu_op = 2'b01;
            pc_src = 2'b01;
            pc_we  = zero;
            retire = 1'b1;
          end
          C_BNE: begin
            alu_op = 2'b01;
            pc_src = 2'b01;
            pc_we  = ~zero;
            retire = 1'b1;
          end
          C_JMP: begin
            pc_src = 2'b10;
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          default: begin
            state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        // Address operands held so the address stays stable while waiting.
        dmem_req = 1'b1;
        dmem_we  = (class_q == C_SW);
        alu_op   = 2'b10;
        alu_src  = 1'b1;
        if (dmem_ready) begin
          if (class_q == C_SW) retire  = 1'b1;
          else                 state_d = S_WB;
        end else if (timeout) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (class_q == C_RTYPE);
        mem_to_reg = (class_q == C_LW);
        retire     = 1'b1;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    if (retire) begin
      state_d = halt ? S_IDLE : S_FETCH;
      wait_d  = '0;
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  assign err_d     = err_q | (state_d == S_ERR);

  // Sequencer state, latched class, wait counter, retire count and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q   <= S_IDLE;
      class_q   <= C_RTYPE;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      if (state_q == S_DECODE) class_q <= class_d;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err     = err_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the 16-bit RISC core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB phases, and handshakes with instruction and data memory through req/ready pairs. It gates the datapath control (ALU op, mux selects, write enables) so that each signal is active only in its phase. It also resolves BEQ/BNE/JMP PC updates and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: cycles a memory request may wait for ready before ERR (≥1)
- CNT_W, 16: width of retired-instruction counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- halt  in  1  sampled at retirement; return to IDLE instead of FETCH
- opcode  in  4  instruction[15:12]; valid in DECODE
- zero  in  1  ALU zero flag; valid in EXEC
- imem_ready  in  1  instruction word available
- dmem_ready  in  1  data access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  00 PC+2, 01 branch target, 10 jump target
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write (SW)
- alu_op  out  2  00 R-type, 01 compare (branch), 10 address add
- alu_src  out  1  1 = immediate operand
- reg_dst  out  1  1 = rd field, 0 = rt field
- mem_to_reg  out  1  1 = write-back from memory
- reg_we  out  1  register file write
- busy  out  1  state not IDLE/ERR
- err  out  1  memory timeout, sticky until rst
- retired  out  CNT_W  retired instruction count
- state  out  3  current state, debug

## Operation
- Opcode classes:
  - 0000 LW
  - 0001 SW
  - 1010 BEQ
  - 1011 BNE
  - 1100 JMP
  - 0010–1001 and 1101–1111 are R-type.
- The class is latched into an internal register at DECODE. It is held until the next DECODE and drives the control outputs.
- States (encoding): IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, ERR 6.
- IDLE: all outputs 0. start=1 → FETCH.
- FETCH: imem_req=1.
  - On imem_ready: ir_we=1, pc_we=1, pc_src=00 for that cycle, then → DECODE.
- DECODE: latch class → EXEC.
- EXEC: alu_op/alu_src driven per class; alu_src=1 only for LW/SW.
  - BEQ: pc_we=(zero), pc_src=01. BNE: pc_we=(~zero), pc_src=01. Both retire.
  - JMP: pc_we=1, pc_src=10, retire.
  - LW/SW → MEM. R-type → WB.
- MEM: dmem_req=1, dmem_we=(SW), alu_op=10, alu_src=1 held so the address stays stable.
  - On dmem_ready: SW retires; LW → WB.
- WB: reg_we=1 for one cycle. reg_dst=1 for R-type and 0 for LW; mem_to_reg=1 for LW. Retire.
- Retire:
  - retired increments by 1 and wraps from all-ones to 0.
  - Next state is IDLE if halt=1 in that cycle, else FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle the relevant ready is 0.
  - If ready is still 0 in the MEM_TIMEOUT-th waiting cycle → ERR.
  - ready=1 in that same cycle wins over the timeout.
- ERR: err=1, all other outputs 0 except state. Stays in ERR until rst; start is ignored.

## Timing
- state, latched class, wait counter, retired and err are registered. Control outputs are combinational from state, class, zero and the ready inputs.
- ir_we/pc_we in FETCH and retirement in MEM are Mealy outputs, qualified by ready in the same cycle.
- Reset value of every output is 0: state=IDLE, retired=0, err=0, counters 0.
- Assertion of rst mid-instruction aborts immediately: no write enable may be high after rst rises.
- Cycle counts with zero-wait memory:
  - R-type 4 (F,D,E,W)
  - LW 5 (F,D,E,M,W)
  - SW 4 (F,D,E,M)
  - BEQ/BNE/JMP 3 (F,D,E)
- Each wait cycle adds 1.
- imem_req/dmem_req stay high, unchanged, until ready. Ready sampled outside FETCH/MEM is ignored.
- start high during busy is ignored. halt only matters in the retirement cycle.

## Test plan
- Reset, then start pulse with opcode 0010, zero-wait imem → ir_we@FETCH, reg_we=1 reg_dst=1 in cycle 4, retired=1, back in FETCH cycle 5.
- LW (0000) with dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0, then WB with mem_to_reg=1, total 8 cycles.
- SW (0001) zero-wait → dmem_we=1 for 1 cycle, reg_we never 1, retired +1 after 4 cycles.
- BEQ with zero=1 → pc_we=1 pc_src=01 in EXEC. BNE with zero=1 → pc_we=0. JMP → pc_src=10. Each takes 3 cycles.
- imem_ready held 0 (MEM_TIMEOUT=15) → ERR entered after 15 waiting cycles, err=1 sticky, start ignored. Ready arriving on the 15th cycle → no ERR.
- halt=1 at WB → IDLE, busy=0. rst asserted in MEM → all outputs 0 immediately. Preload retired=16'hFFFF via 65535 retirements (or force) → wraps to 0.
